// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx byte stream between num_ports requesters.
// The owner's stream is passed straight through; an optional idle gap separates packets.
module uart_tx_arbiter #(
   parameter int unsigned num_ports  = 4,
   parameter int unsigned gap_cycles = 0,
   parameter int unsigned max_beats  = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [num_ports-1:0]   s_tvalid,
   output logic [num_ports-1:0]   s_tready,
   input  logic [8*num_ports-1:0] s_tdata,
   input  logic [num_ports-1:0]   s_tlast,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [7:0]             m_tdata,
   output logic [num_ports-1:0]   grant,
   output logic                   trunc
);

   localparam int unsigned idx_w  = $clog2(num_ports);
   localparam int unsigned beat_w = $clog2(max_beats + 1);
   localparam int unsigned gap_w  = 16;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      GAP
   } state_t;

   state_t             state, state_d;
   logic [idx_w-1:0]   idx, idx_d;
   logic [idx_w-1:0]   last_idx, last_idx_d;
   logic [idx_w-1:0]   cand;
   logic [beat_w-1:0]  beat, beat_d;
   logic [gap_w-1:0]   gap_cnt, gap_d;
   logic               trunc_d;
   logic               found;
   logic               xfer;
   logic               release_pkt;
   int unsigned        scan;

   // State and bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         last_idx <= idx_w'(num_ports - 1);
         beat     <= '0;
         gap_cnt  <= '0;
         trunc    <= 1'b0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         last_idx <= last_idx_d;
         beat     <= beat_d;
         gap_cnt  <= gap_d;
         trunc    <= trunc_d;
      end
   end

   // Next-state logic and owner pass-through
   always_comb begin
      state_d     = state;
      idx_d       = idx;
      last_idx_d  = last_idx;
      beat_d      = beat;
      gap_d       = gap_cnt;
      trunc_d     = 1'b0;
      s_tready    = '0;
      m_tvalid    = 1'b0;
      m_tdata     = '0;
      grant       = '0;
      found       = 1'b0;
      xfer        = 1'b0;
      release_pkt = 1'b0;
      scan        = 0;
      cand        = '0;

      case (state)
         IDLE: begin
            // Rotate starting just after the previous owner
            for (int unsigned k = 1; k <= num_ports; k++) begin
               scan = (32'(last_idx) + k) % num_ports;
               cand = idx_w'(scan);
               if (!found && s_tvalid[cand]) begin
                  found      = 1'b1;
                  idx_d      = cand;
                  last_idx_d = cand;
               end
            end
            if (found) begin
               beat_d  = '0;
               state_d = STREAM;
            end
         end

         STREAM: begin
            grant[idx]    = 1'b1;
            m_tvalid      = s_tvalid[idx];
            m_tdata       = s_tvalid[idx] ? s_tdata[{idx, 3'b000} +: 8] : 8'h00;
            s_tready[idx] = m_tready;
            xfer          = s_tvalid[idx] & m_tready;
            if (xfer) begin
               beat_d = beat + beat_w'(1);
               if (s_tlast[idx]) begin
                  release_pkt = 1'b1;
               end else if (beat == beat_w'(max_beats - 1)) begin
                  release_pkt = 1'b1;
                  trunc_d     = 1'b1;
               end
            end
            if (release_pkt) begin
               if (gap_cycles > 0) begin
                  state_d = GAP;
                  gap_d   = gap_w'(gap_cycles - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end

         GAP: begin
            if (gap_cnt == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_cnt - gap_w'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle-level reference model plus directed literal checks
// and a randomized multi-port packet run.
module tb_uart_tx_arbiter;

   localparam int NP   = 4;
   localparam int GAP  = 3;
   localparam int MAXB = 4;
   localparam int QD   = 2048;
   localparam int LD   = 4096;

   localparam int T5P [8] = '{0, 0, 0, 0, 3, 3, 0, 0};
   localparam int T5D [8] = '{'h50, 'h51, 'h52, 'h53, 'h60, 'h61, 'h54, 'h55};

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [NP-1:0]   s_tvalid;
   logic [NP-1:0]   s_tready;
   logic [8*NP-1:0] s_tdata;
   logic [NP-1:0]   s_tlast;
   logic            m_tvalid;
   logic            m_tready;
   logic [7:0]      m_tdata;
   logic [NP-1:0]   grant;
   logic            trunc;

   uart_tx_arbiter #(
      .num_ports (NP),
      .gap_cycles(GAP),
      .max_beats (MAXB)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .s_tdata (s_tdata),
      .s_tlast (s_tlast),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tdata (m_tdata),
      .grant   (grant),
      .trunc   (trunc)
   );

   initial forever #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-port byte sources
   logic [7:0] qd [NP][QD];
   logic       ql [NP][QD];
   int         head [NP];
   int         tail [NP];
   int         ready_mode = 0;
   bit         rand_valid = 1'b0;
   logic [NP-1:0] acc;

   task automatic push(input int p, input logic [7:0] d, input logic l);
      qd[p][tail[p]] = d;
      ql[p][tail[p]] = l;
      tail[p]++;
   endtask

   task automatic push_pkt(input int p, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) push(p, 8'(int'(base) + k), (k == n - 1));
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < NP; i++) s += tail[i] - head[i];
      return s;
   endfunction

   // Driver: pops accepted bytes, then presents the next head of each queue
   initial begin
      logic [NP-1:0] gate;
      for (int i = 0; i < NP; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      acc      = '0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NP; i++) if (acc[i]) head[i]++;
         gate = rand_valid ? NP'($urandom_range(0, 15) | $urandom_range(0, 15)) : '1;
         for (int i = 0; i < NP; i++) begin
            if (head[i] < tail[i] && gate[i]) begin
               s_tvalid[i]        = 1'b1;
               s_tdata[8*i +: 8]  = qd[i][head[i]];
               s_tlast[i]         = ql[i][head[i]];
            end else begin
               s_tvalid[i]        = 1'b0;
               s_tdata[8*i +: 8]  = 8'($urandom);
               s_tlast[i]         = 1'($urandom);
            end
         end
         case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Reference model: owner (-1 when none), bytes sent in current grant, idle cycles before arbitration
   int   own = -1;
   int   last_own = NP - 1;
   int   sent = 0;
   int   idle_left = 0;
   logic mtrunc = 1'b0;
   int   cyc = 0;
   logic [NP-1:0] prev_v = '0;
   int   vrise [NP];

   int   log_port [LD];
   int   log_data [LD];
   int   log_cyc  [LD];
   int   log_grant[LD];
   int   log_n = 0;
   int   trunc_cyc[LD];
   int   trunc_n = 0;

   initial begin
      logic          e_mv;
      logic [7:0]    e_md;
      logic [NP-1:0] e_rdy;
      logic [NP-1:0] e_g;
      int            gp;
      int            p;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            own = -1; last_own = NP - 1; sent = 0; idle_left = 0; mtrunc = 1'b0;
            acc = '0;
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_tdata", m_tdata, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_grant", grant, 0);
            chk("rst_trunc", trunc, 0);
            prev_v = s_tvalid;
         end else begin
            e_rdy = '0;
            e_g   = '0;
            e_mv  = 1'b0;
            e_md  = 8'h00;
            if (own >= 0) begin
               e_mv       = s_tvalid[own];
               e_md       = e_mv ? s_tdata[8*own +: 8] : 8'h00;
               e_rdy[own] = m_tready;
               e_g[own]   = 1'b1;
            end
            chk("m_tvalid", m_tvalid, e_mv);
            chk("m_tdata", m_tdata, e_md);
            chk("s_tready", s_tready, e_rdy);
            chk("grant", grant, e_g);
            chk("trunc", trunc, mtrunc);

            acc = s_tvalid & s_tready;
            for (int i = 0; i < NP; i++) if (s_tvalid[i] && !prev_v[i]) vrise[i] = cyc;
            prev_v = s_tvalid;
            if (m_tvalid && m_tready && log_n < LD) begin
               gp = -1;
               for (int i = 0; i < NP; i++) if (grant[i]) gp = i;
               log_port[log_n]  = gp;
               log_data[log_n]  = int'(m_tdata);
               log_cyc[log_n]   = cyc;
               log_grant[log_n] = int'(grant);
               log_n++;
            end
            if (trunc && trunc_n < LD) begin
               trunc_cyc[trunc_n] = cyc;
               trunc_n++;
            end

            // Advance the model across the coming rising edge
            mtrunc = 1'b0;
            if (own >= 0) begin
               if (s_tvalid[own] && m_tready) begin
                  sent++;
                  if (s_tlast[own] || sent == MAXB) begin
                     mtrunc    = !s_tlast[own];
                     own       = -1;
                     idle_left = GAP;
                  end
               end
            end else if (idle_left > 0) begin
               idle_left--;
            end else begin
               for (int k = 1; k <= NP; k++) begin
                  p = (last_own + k) % NP;
                  if (own < 0 && s_tvalid[p]) begin
                     own      = p;
                     last_own = p;
                     sent     = 0;
                  end
               end
            end
         end
      end
   end

   task automatic wait_log(input int target, input int budget);
      int c = 0;
      while (log_n < target && c < budget) begin
         @(negedge clk);
         #2;
         c++;
      end
      chk("log_timeout", (log_n >= target), 1);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (pending() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      repeat (GAP + MAXB + 4) @(negedge clk);
      #2;
      chk("drain_pending", pending(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int n0;
      int tn0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_m_tvalid", m_tvalid, 0);
      chk("reset_grant", grant, 0);
      chk("reset_s_tready", s_tready, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Idle: model checks every cycle
      repeat (100) @(negedge clk);

      // Single 3-byte packet on port 2
      #2;
      n0 = log_n;
      push_pkt(2, 3, 8'h41);
      wait_log(n0 + 3, 60);
      for (int k = 0; k < 3; k++) begin
         chk("t2_data", log_data[n0+k], 32'h41 + k);
         chk("t2_grant", log_grant[n0+k], 32'b0100);
      end
      chk("t2_latency", log_cyc[n0] - vrise[2], 1);
      wait_idle(200);

      // All ports, 1-byte packets: strict rotation from port 0
      do_reset();
      n0 = log_n;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) push_pkt(p, 1, 8'(16 * p + r));
      wait_log(n0 + 8, 300);
      for (int k = 0; k < 8; k++) chk("t3_order", log_port[n0+k], k % NP);
      wait_idle(200);

      // Inter-packet idle time
      n0 = log_n;
      push_pkt(1, 1, 8'h11);
      push_pkt(1, 1, 8'h12);
      wait_log(n0 + 2, 100);
      chk("t4_idle_cycles", log_cyc[n0+1] - log_cyc[n0] - 1, GAP + 1);
      wait_idle(200);

      // Forced release at max_beats
      do_reset();
      #2;
      n0  = log_n;
      tn0 = trunc_n;
      push_pkt(0, 6, 8'h50);
      push_pkt(3, 2, 8'h60);
      wait_log(n0 + 8, 300);
      for (int k = 0; k < 8; k++) begin
         chk("t5_port", log_port[n0+k], T5P[k]);
         chk("t5_data", log_data[n0+k], T5D[k]);
      end
      chk("t5_trunc_count", trunc_n - tn0, 1);
      chk("t5_trunc_timing", trunc_cyc[tn0] - log_cyc[n0+3], 1);
      wait_idle(200);

      // Toggling m_tready: no loss or duplication
      ready_mode = 1;
      n0 = log_n;
      push_pkt(1, 5, 8'hA0);
      wait_log(n0 + 5, 300);
      for (int k = 0; k < 5; k++) chk("t6_data", log_data[n0+k], 32'hA0 + k);
      wait_idle(300);
      ready_mode = 0;

      // Reset while byte 2 of a packet is on the bus
      n0 = log_n;
      push_pkt(1, 4, 8'hB0);
      wait_log(n0 + 1, 100);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_m_tvalid", m_tvalid, 0);
      chk("t6_rst_m_tdata", m_tdata, 0);
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_s_tready", s_tready, 0);
      push_pkt(0, 1, 8'hC0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      wait_log(n0 + 2, 100);
      chk("t6_first_port", log_port[n0+1], 0);
      chk("t6_first_data", log_data[n0+1], 32'hC0);
      wait_idle(300);
      chk("t6_resume_byte", log_data[n0+2], 32'hB1);

      // Randomized traffic
      do_reset();
      ready_mode = 2;
      rand_valid = 1'b1;
      for (int k = 0; k < 40; k++)
         push_pkt($urandom_range(0, NP - 1), $urandom_range(1, 6), 8'($urandom));
      wait_idle(20000);
      ready_mode = 0;
      rand_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
